// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: default widths and the occupancy state encoding.
package pipe_pkg;

  localparam int unsigned PIPE_DATA_W = 64;
  localparam int unsigned PIPE_CNT_W  = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry skid storage with registered ready; head entry drives the stage output.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W    = PIPE_DATA_W,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              clear,
  input  logic              accept,
  input  logic              deliver,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] head_data,
  output logic              head_valid,
  output logic              ready_q
);

  pipe_state_e       state_q, state_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= RESET_VAL;
      tail_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      ready_q <= (state_d != TWO);
    end
  end

  // Occupancy transitions; accept never arrives in TWO because ready is low there.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (!hold) begin
      if (clear) begin
        state_d = EMPTY;
        head_d  = RESET_VAL;
      end else begin
        case (state_q)
          EMPTY: begin
            if (accept) begin
              state_d = ONE;
              head_d  = in_data;
            end
          end
          ONE: begin
            if (accept && deliver) begin
              head_d = in_data;
            end else if (accept) begin
              state_d = TWO;
              tail_d  = in_data;
            end else if (deliver) begin
              state_d = EMPTY;
            end
          end
          TWO: begin
            if (deliver) begin
              state_d = ONE;
              head_d  = tail_q;
            end
          end
          default: state_d = EMPTY;
        endcase
      end
    end
  end

  assign head_data  = head_q;
  assign head_valid = (state_q != EMPTY);

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage with freeze, deferred flush and saturating stall counter.
// Define PIPE_STAGE_REG_SKID_EN to build the two-entry skid buffer instead of the single register.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W    = PIPE_DATA_W,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int unsigned       CNT_W     = PIPE_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              freeze,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic flush_pend_q;
  logic apply_flush;
  logic hold_valid;
  logic accept;
  logic deliver;
  logic stall;

  // A flush seen while frozen is remembered and applied on the first unfrozen cycle.
  assign apply_flush = !freeze && (flush || flush_pend_q);
  assign out_valid   = hold_valid && !freeze;
  assign accept      = in_valid && in_ready;
  assign deliver     = out_valid && out_ready;
  assign stall       = freeze || (out_valid && !out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_pend_q <= 1'b0;
    end else if (freeze && flush) begin
      flush_pend_q <= 1'b1;
    end else if (apply_flush) begin
      flush_pend_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

`ifdef PIPE_STAGE_REG_SKID_EN
  logic buf_ready;

  pipe_skid_buf #(
    .DATA_W    (DATA_W),
    .RESET_VAL (RESET_VAL)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .hold       (freeze),
    .clear      (apply_flush),
    .accept     (accept),
    .deliver    (deliver),
    .in_data    (in_data),
    .head_data  (out_data),
    .head_valid (hold_valid),
    .ready_q    (buf_ready)
  );

  assign in_ready = buf_ready && !freeze;
`else
  pipe_state_e       state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              rdy_en_q;

  // rdy_en_q keeps in_ready low through reset and releases it on the first edge after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= EMPTY;
      data_q   <= RESET_VAL;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      rdy_en_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (!freeze) begin
      if (apply_flush) begin
        state_d = EMPTY;
        data_d  = RESET_VAL;
      end else begin
        case (state_q)
          EMPTY: begin
            if (accept) begin
              state_d = ONE;
              data_d  = in_data;
            end
          end
          ONE: begin
            if (accept) begin
              data_d = in_data;
            end else if (deliver) begin
              state_d = EMPTY;
            end
          end
          default: state_d = EMPTY;
        endcase
      end
    end
  end

  assign hold_valid = (state_q == ONE);
  assign out_data   = data_q;
  assign in_ready   = rdy_en_q && !freeze && (!out_valid || out_ready);
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus randomized traffic against a queue model.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_REG_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  localparam logic [63:0] RV = 64'hDEAD_BEEF_0BAD_F00D;

  logic        clk = 1'b0;
  logic        rst, flush, freeze, in_valid, out_ready;
  logic [63:0] in_data;
  logic        in_ready, out_valid;
  logic [63:0] out_data;
  logic [15:0] stall_cnt;
  logic        s_in_ready, s_out_valid;
  logic [7:0]  s_out_data;
  logic [3:0]  s_stall_cnt;

  int tests = 0;
  int fails = 0;

  // Reference model: an ordered queue of held entries plus the visible output word.
  logic [63:0] mq[$];
  logic [63:0] m_data;
  bit          m_pend, m_rdy_en;
  int          m_cnt, m_scnt;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(64), .RESET_VAL(RV), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.DATA_W(8), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data[7:0]),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .stall_cnt(s_stall_cnt)
  );

  function automatic bit exp_valid();
    return !freeze && (mq.size() > 0);
  endfunction

  function automatic bit exp_ready();
    if (!m_rdy_en || freeze) return 1'b0;
    if (SKID) return mq.size() < 2;
    return (mq.size() == 0) || out_ready;
  endfunction

  task automatic drive(input bit fr, input bit fl, input bit iv, input logic [63:0] id, input bit ordy);
    freeze = fr; flush = fl; in_valid = iv; in_data = id; out_ready = ordy;
    #1;
  endtask

  // Advance one clock edge and update the model from the inputs presented in this cycle.
  task automatic tick();
    bit ev, acc, del;
    ev  = exp_valid();
    acc = in_valid && exp_ready();
    del = ev && out_ready;
    @(posedge clk);
    if (freeze) begin
      if (flush) m_pend = 1'b1;
    end else if (flush || m_pend) begin
      mq.delete();
      m_data = RV;
      m_pend = 1'b0;
    end else begin
      if (del) void'(mq.pop_front());
      if (acc) mq.push_back(in_data);
      if (mq.size() > 0) m_data = mq[0];
    end
    if (freeze || (ev && !out_ready)) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_scnt < 15) m_scnt++;
    end
    m_rdy_en = 1'b1;
    #1;
  endtask

  task automatic assert_rst();
    rst = 1'b1;
    #1;
    mq.delete();
    m_data = RV; m_pend = 1'b0; m_cnt = 0; m_scnt = 0; m_rdy_en = 1'b0;
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 64'h0, 0);
    @(negedge clk);
    assert_rst();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++; if (out_data !== RV) begin fails++; $display("FAIL reset_out_data got %h want %h", out_data, RV); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    tests++; if (stall_cnt !== 16'd0) begin fails++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
    release_rst();
    drive(0, 0, 0, 64'h0, 1);
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_ready_before_edge got %b want 0", in_ready); end
    tick();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready_after_edge got %b want 1", in_ready); end
  endtask

  task automatic test_streaming();
    for (int k = 1; k <= 8; k++) begin
      drive(0, 0, 1, 64'(k), 1);
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stream_ready k=%0d got %b want 1", k, in_ready); end
      tick();
      tests++;
      if (out_valid !== 1'b1 || out_data !== 64'(k)) begin
        fails++; $display("FAIL stream_out k=%0d got v=%b d=%h want v=1 d=%h", k, out_valid, out_data, 64'(k));
      end
    end
    drive(0, 0, 0, 64'h0, 1);
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stream_drained got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [15:0] base;
    base = 16'(m_cnt);
    drive(0, 0, 1, 64'hA, 0);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_first_ready got %b want 1", in_ready); end
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 64'hB, 0);
      tests++;
      if (out_valid !== 1'b1 || out_data !== 64'hA) begin
        fails++; $display("FAIL bp_hold i=%0d got v=%b d=%h want v=1 d=a", i, out_valid, out_data);
      end
      tests++;
      if (in_ready !== (SKID && i == 0)) begin
        fails++; $display("FAIL bp_in_ready i=%0d got %b want %b", i, in_ready, SKID && i == 0);
      end
      tick();
    end
    drive(0, 0, 0, 64'h0, 1);
    tests++; if (stall_cnt !== base + 16'd3) begin fails++; $display("FAIL bp_stall_cnt got %0d want %0d", stall_cnt, base + 16'd3); end
    tests++; if (out_data !== 64'hA) begin fails++; $display("FAIL bp_head got %h want a", out_data); end
    tick();
    tests++;
    if (SKID) begin
      if (out_valid !== 1'b1 || out_data !== 64'hB) begin
        fails++; $display("FAIL bp_skid_second got v=%b d=%h want v=1 d=b", out_valid, out_data);
      end
    end else if (out_valid !== 1'b0) begin
      fails++; $display("FAIL bp_single_empty got v=%b want 0", out_valid);
    end
    tick();
  endtask

  task automatic test_frozen_flush();
    drive(0, 0, 1, 64'h77, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, i == 0, 0, 64'h0, 1);
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== 64'h77) begin
        fails++; $display("FAIL ff_frozen i=%0d got v=%b r=%b d=%h want v=0 r=0 d=77", i, out_valid, in_ready, out_data);
      end
      tick();
    end
    drive(0, 0, 0, 64'h0, 0);
    tick();
    drive(0, 0, 0, 64'h0, 1);
    tests++;
    if (out_valid !== 1'b0 || out_data !== RV) begin
      fails++; $display("FAIL ff_applied got v=%b d=%h want v=0 d=%h", out_valid, out_data, RV);
    end
    drive(0, 0, 1, 64'h99, 1);
    tick();
    tests++;
    if (out_valid !== 1'b1 || out_data !== 64'h99) begin
      fails++; $display("FAIL ff_pend_cleared got v=%b d=%h want v=1 d=99", out_valid, out_data);
    end
  endtask

  task automatic test_flush_race();
    drive(0, 1, 1, 64'h55, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 64'h0, 1);
      tests++;
      if (out_valid !== 1'b0 || out_data === 64'h55 || out_data !== RV) begin
        fails++; $display("FAIL race_after_flush i=%0d got v=%b d=%h want v=0 d=%h", i, out_valid, out_data, RV);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    drive(0, 0, 1, 64'h1, 0);
    tick();
    drive(0, 0, 1, 64'h2, 0);
    tick();
    drive(0, 0, 0, 64'h0, 1);
    @(negedge clk);
    assert_rst();
    tests++;
    if (out_valid !== 1'b0 || out_data !== RV || in_ready !== 1'b0 || stall_cnt !== 16'd0) begin
      fails++; $display("FAIL async_rst got v=%b d=%h r=%b c=%0d want v=0 d=%h r=0 c=0", out_valid, out_data, in_ready, stall_cnt, RV);
    end
    release_rst();
    tick();
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL async_rst_recover got r=%b v=%b want r=1 v=0", in_ready, out_valid);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 0, 64'h0, 0);
      tick();
    end
    tests++; if (s_stall_cnt !== 4'd15) begin fails++; $display("FAIL sat_cnt4 got %0d want 15", s_stall_cnt); end
    tests++; if (stall_cnt !== 16'd20) begin fails++; $display("FAIL sat_cnt16 got %0d want 20", stall_cnt); end
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 64'h0, 0);
      tick();
    end
    tests++; if (s_stall_cnt !== 4'd15) begin fails++; $display("FAIL sat_hold got %0d want 15", s_stall_cnt); end
    tests++; if (stall_cnt !== 16'd25) begin fails++; $display("FAIL sat_cnt16_more got %0d want 25", stall_cnt); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 9) == 0, $urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)),
            {$urandom, $urandom}, $urandom_range(0, 3) != 0);
      tests++;
      if (out_valid !== exp_valid() || in_ready !== exp_ready() || out_data !== m_data) begin
        fails++;
        $display("FAIL rand_outputs n=%0d got v=%b r=%b d=%h want v=%b r=%b d=%h",
                 n, out_valid, in_ready, out_data, exp_valid(), exp_ready(), m_data);
      end
      tests++;
      if (stall_cnt !== 16'(m_cnt) || s_stall_cnt !== 4'(m_scnt)) begin
        fails++;
        $display("FAIL rand_stall n=%0d got %0d/%0d want %0d/%0d", n, stall_cnt, s_stall_cnt, m_cnt, m_scnt);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; freeze = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    m_data = RV; m_pend = 1'b0; m_rdy_en = 1'b0; m_cnt = 0; m_scnt = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_frozen_flush();
    test_flush_race();
    test_async_reset();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached after %0d checks", tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning payload width (PC and instruction concatenated).
REQ-002 SHALL have parameter RESET_VAL, default all-zero DATA_W, meaning the out_data value after reset or flush.
REQ-003 SHALL have parameter CNT_W, default 16, meaning the stall counter width.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port flush, input, 1, synchronous request to discard all held entries.
REQ-007 SHALL have port freeze, input, 1, which holds all state for the cycle.
REQ-008 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, DATA_W), the upstream handshake.
REQ-009 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, DATA_W), the downstream handshake.
REQ-010 SHALL have port stall_cnt, output, CNT_W, the saturating count of stalled cycles.

Function
REQ-011 SHALL accept data only when in_valid && in_ready, and SHALL deliver data only when out_valid && out_ready.
REQ-012 SHALL preserve order; no entry is duplicated or dropped except by flush.
REQ-013 SHALL give one-cycle latency: data accepted at edge N appears on out_data after edge N, provided the stage was empty or draining.
REQ-014 SHALL force in_ready=0 and out_valid=0 while freeze=1, holding all entries, out_data and the FSM state unchanged.
REQ-015 SHALL, when flush=1 and freeze=0, set out_valid=0 and out_data=RESET_VAL after the edge, empty all entries and ignore any same-cycle input transfer.
REQ-016 SHALL, when flush=1 and freeze=1, latch a pending-flush flag and apply the flush on the first cycle with freeze=0, whatever flush is in that cycle.
REQ-017 SHALL clear the pending-flush flag when the flush is applied.
REQ-018 SHALL keep out_data stable while out_valid=1 and out_ready=0.
REQ-019 SHALL increment stall_cnt each cycle in which freeze=1, or out_valid=1 and out_ready=0, saturating at all-ones with no wrap.
REQ-020 SHALL not clear stall_cnt on flush.
REQ-021 SHALL, on a simultaneous accept and deliver, replace the entry with no bubble.

Reset
REQ-022 SHALL on rst=1 immediately set out_valid=0, out_data=RESET_VAL, in_ready=0, stall_cnt=0, FSM state EMPTY and pending-flush=0, independent of clk.
REQ-023 SHALL raise in_ready on the first edge after rst deasserts, freeze permitting.
REQ-024 SHALL discard any in-flight entry when rst asserts mid-transfer.

Configuration
REQ-025 SHALL compile in a 2-entry skid buffer when macro PIPE_STAGE_REG_SKID_EN is defined, with FSM states EMPTY, ONE and TWO: in_ready is registered and equals !freeze && state!=TWO; ONE->TWO on accept without deliver; TWO->ONE on deliver; EMPTY<->ONE on accept/deliver.
REQ-026 SHALL, without PIPE_STAGE_REG_SKID_EN, use a single register with combinational in_ready = !freeze && (!out_valid || out_ready), and SHALL use only states EMPTY and ONE.
REQ-027 SHALL give identical REQ-011..REQ-024 behaviour in both builds, except for in_ready timing.

Structure
REQ-028 SHALL define the state enum (EMPTY, ONE, TWO) and the default width constants in shared package pipe_pkg.
REQ-029 SHALL place the skid storage and its FSM in sub-module pipe_skid_buf, instantiated only under PIPE_STAGE_REG_SKID_EN.

Verification
REQ-030 SHALL cover streaming: in_valid=1 and out_ready=1 with data 1..8 -> out_data 1..8 on consecutive cycles, one-cycle latency, no bubbles.
REQ-031 SHALL cover backpressure: out_ready=0 for 3 cycles with data 0xA, 0xB offered -> out_data holds 0xA; in SKID build 0xB is also accepted and then in_ready=0; stall_cnt=3.
REQ-032 SHALL cover frozen flush: flush pulsed during freeze with one entry held -> unchanged while frozen; on the first unfrozen cycle out_valid=0 and out_data=RESET_VAL.
REQ-033 SHALL cover flush racing input: flush=1 with in_valid=1 and data 0x55 -> out_valid=0 next cycle and 0x55 never appears.
REQ-034 SHALL cover async reset: rst asserted mid-cycle with TWO entries -> outputs go to reset values before the next clk edge.
REQ-035 SHALL cover saturation: CNT_W=4 with 20 stall cycles -> stall_cnt=15 and holds at 15.
